// File: rtl/pwm_multicanal.sv
// N-channel PWM / first-order sigma-delta generator on a single clock.
// A prescaler tick paces the counters; duties are double-buffered (pend -> act).
module pwm_multicanal #(
    parameter int unsigned cant_bits    = 8,
    parameter int unsigned cant_canales = 4,
    parameter int unsigned presc_bits   = 8,
    localparam int unsigned CanalW      = (cant_canales > 1) ? $clog2(cant_canales) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    modo,
    input  logic [presc_bits-1:0]   presc,
    input  logic [cant_bits-1:0]    periodo,
    input  logic                    wr_en,
    input  logic [CanalW-1:0]       wr_canal,
    input  logic [cant_bits-1:0]    wr_dato,
    output logic [cant_canales-1:0] PWM_out,
    output logic                    fin_periodo
);

    logic [presc_bits-1:0]   presc_cnt_q, presc_cnt_d;
    logic [cant_bits-1:0]    contador_q, contador_d;
    logic [cant_bits-1:0]    pend_q [cant_canales];
    logic [cant_bits-1:0]    pend_d [cant_canales];
    logic [cant_bits-1:0]    act_q  [cant_canales];
    logic [cant_bits-1:0]    act_d  [cant_canales];
    logic [cant_bits:0]      acc_q  [cant_canales];
    logic [cant_bits:0]      acc_d  [cant_canales];
    logic [cant_canales-1:0] pwm_q, pwm_d;
    logic                    fin_q, fin_d;
    logic                    modo_q;
    logic                    run, tick, bnd;

    always_comb begin
        // A mode change costs one clearing clock before the new mode runs.
        run  = en && (modo == modo_q);
        tick = run && (presc_cnt_q == presc);
        bnd  = tick && (modo_q || (contador_q == periodo));

        presc_cnt_d = '0;
        if (run) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + presc_bits'(1);
        end

        contador_d = '0;
        if (run && !modo_q) begin
            contador_d = contador_q;
            if (tick) begin
                contador_d = (contador_q == periodo) ? '0 : contador_q + cant_bits'(1);
            end
        end

        fin_d = bnd && !modo_q;

        for (int k = 0; k < cant_canales; k++) begin
            pend_d[k] = pend_q[k];
            if (wr_en && (wr_canal == CanalW'(k))) begin
                pend_d[k] = wr_dato;
            end

            // Using pend_d lets a same-clock write land directly in act.
            act_d[k] = act_q[k];
            if (!en || bnd) begin
                act_d[k] = pend_d[k];
            end

            acc_d[k] = '0;
            pwm_d[k] = 1'b0;
            if (run && modo_q) begin
                acc_d[k] = acc_q[k];
                if (tick) begin
                    acc_d[k] = {1'b0, acc_q[k][cant_bits-1:0]} + {1'b0, act_q[k]};
                end
                pwm_d[k] = acc_q[k][cant_bits];
            end else if (run) begin
                pwm_d[k] = (contador_q < act_q[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt_q <= '0;
            contador_q  <= '0;
            pwm_q       <= '0;
            fin_q       <= 1'b0;
            modo_q      <= 1'b0;
            for (int k = 0; k < cant_canales; k++) begin
                pend_q[k] <= '0;
                act_q[k]  <= '0;
                acc_q[k]  <= '0;
            end
        end else begin
            presc_cnt_q <= presc_cnt_d;
            contador_q  <= contador_d;
            pwm_q       <= pwm_d;
            fin_q       <= fin_d;
            modo_q      <= modo;
            for (int k = 0; k < cant_canales; k++) begin
                pend_q[k] <= pend_d[k];
                act_q[k]  <= act_d[k];
                acc_q[k]  <= acc_d[k];
            end
        end
    end

    assign PWM_out     = pwm_q;
    assign fin_periodo = fin_q;

endmodule

// File: tb/tb_pwm_multicanal.sv
// Bench for pwm_multicanal: per-cycle comparison against an integer model of the
// channel behaviour, plus directed high-count checks that pin the model.
module tb_pwm_multicanal;

    localparam int NB  = 8;
    // Five channels give a 3-bit channel index, so index 7 is out of range.
    localparam int NCH = 5;
    localparam int CW  = 3;

    logic           clk      = 1'b0;
    logic           rst      = 1'b0;
    logic           en       = 1'b0;
    logic           modo     = 1'b0;
    logic [7:0]     presc    = '0;
    logic [7:0]     periodo  = '0;
    logic           wr_en    = 1'b0;
    logic [CW-1:0]  wr_canal = '0;
    logic [7:0]     wr_dato  = '0;
    logic [NCH-1:0] pwm_out;
    logic           fin;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    pwm_multicanal #(
        .cant_bits   (NB),
        .cant_canales(NCH),
        .presc_bits  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .modo       (modo),
        .presc      (presc),
        .periodo    (periodo),
        .wr_en      (wr_en),
        .wr_canal   (wr_canal),
        .wr_dato    (wr_dato),
        .PWM_out    (pwm_out),
        .fin_periodo(fin)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: integer phase/position per the behavioural rules.
    int             m_pend [NCH];
    int             m_act  [NCH];
    int             m_low  [NCH];
    bit             m_carry[NCH];
    int             m_pcnt;
    int             m_pos;
    bit             m_modo;
    logic [NCH-1:0] e_pwm;
    bit             e_fin;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) begin
                m_pend[k]  = 0;
                m_act[k]   = 0;
                m_low[k]   = 0;
                m_carry[k] = 1'b0;
            end
            m_pcnt = 0;
            m_pos  = 0;
            m_modo = 1'b0;
            e_pwm  = '0;
            e_fin  = 1'b0;
        end else begin
            bit chg, run, tick, bnd, wr_ok;
            int sum;
            chg   = (modo != m_modo);
            run   = en && !chg;
            tick  = run && (m_pcnt == int'(presc));
            bnd   = tick && (m_modo || (m_pos == int'(periodo)));
            wr_ok = wr_en && (int'(wr_canal) < NCH);
            e_fin = bnd && !m_modo;
            for (int k = 0; k < NCH; k++) begin
                if (!run) e_pwm[k] = 1'b0;
                else if (m_modo) e_pwm[k] = m_carry[k];
                else e_pwm[k] = (m_pos < m_act[k]);
                if (wr_ok && (int'(wr_canal) == k)) m_pend[k] = int'(wr_dato);
                if (run && m_modo) begin
                    if (tick) begin
                        sum        = m_low[k] + m_act[k];
                        m_carry[k] = (sum >= 256);
                        m_low[k]   = sum % 256;
                    end
                end else begin
                    m_low[k]   = 0;
                    m_carry[k] = 1'b0;
                end
                if (!en || bnd) m_act[k] = m_pend[k];
            end
            if (run && !m_modo) begin
                if (tick) m_pos = (m_pos == int'(periodo)) ? 0 : (m_pos + 1) % 256;
            end else begin
                m_pos = 0;
            end
            m_pcnt = run ? (tick ? 0 : (m_pcnt + 1) % 256) : 0;
            m_modo = modo;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cycle_pwm_out", int'(pwm_out), int'(e_pwm));
            chk("cycle_fin_periodo", int'(fin), int'(e_fin));
        end
    end

    task automatic wr(input int ch, input int d);
        wr_canal = CW'(ch);
        wr_dato  = 8'(d);
        wr_en    = 1'b1;
        @(negedge clk);
        wr_en    = 1'b0;
    endtask

    initial begin
        int hi, hi2, fc, alt, h1, h2, h3, prev;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_fin", int'(fin), 0);
        rst = 1'b1;

        // Edge-aligned, presc=0, periodo=9, duty 3: 3 high / 7 low, pulse every 10.
        presc   = 8'd0;
        periodo = 8'd9;
        wr(0, 3);
        en = 1'b1;
        hi = 0;
        fc = 0;
        repeat (100) begin
            @(negedge clk);
            hi += int'(pwm_out[0]);
            fc += int'(fin);
        end
        chk("t2_high_of_100", hi, 30);
        chk("t2_fin_of_100", fc, 10);

        // Asynchronous reset mid-cycle while channel 0 is high.
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm_out), 0);
        chk("async_rst_fin", int'(fin), 0);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // presc=4: 50-clock periods; duty 3 -> 7 written mid-period.
        wr(0, 3);
        presc = 8'd4;
        en    = 1'b1;
        hi    = 0;
        hi2   = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i <= 50) hi += int'(pwm_out[0]);
            else hi2 += int'(pwm_out[0]);
            if (i == 20) begin
                wr_canal = 3'd0;
                wr_dato  = 8'd7;
                wr_en    = 1'b1;
            end
            if (i == 21) wr_en = 1'b0;
        end
        chk("t3_first_period_high", hi, 15);
        chk("t3_second_period_high", hi2, 35);

        // Boundary duties and an out-of-range write.
        en    = 1'b0;
        presc = 8'd0;
        wr(0, 0);
        wr(1, 10);
        wr(2, 5);
        wr(3, 2);
        en = 1'b1;
        repeat (20) @(negedge clk);
        wr(7, 99);
        repeat (10) @(negedge clk);
        hi = 0; h1 = 0; h2 = 0; h3 = 0;
        repeat (100) begin
            @(negedge clk);
            hi += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            h2 += int'(pwm_out[2]);
            h3 += int'(pwm_out[3]);
        end
        chk("t4_ch0_duty0", hi, 0);
        chk("t4_ch1_duty_over_period", h1, 100);
        chk("t4_ch2_half", h2, 50);
        chk("t4_ch3_duty2", h3, 20);

        // Sigma-delta: 64/256 and 128/256 densities, no period pulses.
        en   = 1'b0;
        modo = 1'b1;
        wr(0, 64);
        wr(1, 128);
        en = 1'b1;
        repeat (4) @(negedge clk);
        prev = int'(pwm_out[1]);
        hi = 0; h1 = 0; fc = 0; alt = 0;
        repeat (256) begin
            @(negedge clk);
            hi  += int'(pwm_out[0]);
            h1  += int'(pwm_out[1]);
            fc  += int'(fin);
            alt += (int'(pwm_out[1]) != prev) ? 1 : 0;
            prev = int'(pwm_out[1]);
        end
        chk("t5_sd_64_of_256", hi, 64);
        chk("t5_sd_128_of_256", h1, 128);
        chk("t5_sd_alternates", alt, 256);
        chk("t5_sd_no_fin", fc, 0);

        // Mode toggle and enable drop mid-period; pending write during en=0.
        en   = 1'b0;
        modo = 1'b0;
        wr(0, 3);
        wr(1, 255);
        en = 1'b1;
        repeat (10) @(negedge clk);
        modo = 1'b1;
        @(negedge clk);
        chk("t6_modo_change_clears", int'(pwm_out), 0);
        repeat (6) @(negedge clk);
        chk("t6_sd_ch1_high", int'(pwm_out[1]), 1);
        en = 1'b0;
        @(negedge clk);
        chk("t6_en_drop_clears", int'(pwm_out), 0);
        wr(0, 6);
        modo = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        hi = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) chk("t6_restart_first_high", int'(pwm_out[0]), 1);
            hi += int'(pwm_out[0]);
        end
        chk("t6_first_period_new_duty", hi, 6);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
